// File: rtl/alu_seq_pkg.sv
// Shared types for the byte-serial add/subtract sequencer.
// Holds the control state encoding and the datapath byte width.
package alu_seq_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/adder_8bit.sv
// 8-bit ripple-carry adder shared by the byte-serial sequencer.
// Purely combinational; one full-adder cell per bit.
module adder_8bit (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       cin,
   output logic [7:0] sum,
   output logic       cout
);

   logic c;

   // ripple the carry from bit 0 upward
   always_comb begin
      sum = '0;
      c   = cin;
      for (int i = 0; i < 8; i++) begin
         sum[i] = a[i] ^ b[i] ^ c;
         c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      cout = c;
   end

endmodule

// File: rtl/multibyte_add_seq.sv
// Byte-serial NBYTES-wide add/subtract built on one shared 8-bit adder.
// Optional ACC_CHAIN_EN adds req_acc: operand A comes from the last result.
module multibyte_add_seq
   import alu_seq_pkg::*;
#(
   parameter int NBYTES = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_sub,
   input  logic [8*NBYTES-1:0]     req_a,
   input  logic [8*NBYTES-1:0]     req_b,
`ifdef ACC_CHAIN_EN
   input  logic                    req_acc,
`endif
   output logic                    res_valid,
   input  logic                    res_ready,
   output logic [8*NBYTES-1:0]     res_sum,
   output logic                    res_cout,
   output logic                    res_ovf,
   output logic                    busy
);

   localparam int W  = BYTE_W * NBYTES;
   localparam int IW = $clog2(NBYTES) + 1;

   state_t state, state_nx;

   logic [NBYTES-1:0][BYTE_W-1:0] a_q;
   logic [NBYTES-1:0][BYTE_W-1:0] b_q;
   logic                          carry;
   logic [IW-1:0]                 idx;

   logic [BYTE_W-1:0] a_byte;
   logic [BYTE_W-1:0] b_byte;
   logic [BYTE_W-1:0] sum_byte;
   logic              cout_byte;
   logic              last;
   logic [W-1:0]      a_src;
   logic              accept;

   assign last   = (idx == IW'(NBYTES - 1));
   assign accept = req_valid && (state == IDLE);

`ifdef ACC_CHAIN_EN
   assign a_src = req_acc ? res_sum : req_a;
`else
   assign a_src = req_a;
`endif

   // select the operand bytes for the current index
   always_comb begin
      a_byte = '0;
      b_byte = '0;
      for (int i = 0; i < NBYTES; i++) begin
         if (idx == IW'(i)) begin
            a_byte = a_q[i];
            b_byte = b_q[i];
         end
      end
   end

   adder_8bit u_adder (
      .a    (a_byte),
      .b    (b_byte),
      .cin  (carry),
      .sum  (sum_byte),
      .cout (cout_byte)
   );

   // control state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // next-state and handshake outputs
   always_comb begin
      state_nx  = state;
      req_ready = 1'b0;
      res_valid = 1'b0;
      busy      = 1'b1;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            busy      = 1'b0;
            if (req_valid) state_nx = RUN;
         end
         RUN: begin
            if (last) state_nx = DONE;
         end
         DONE: begin
            res_valid = 1'b1;
            if (res_ready) state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // operand capture, carry chain, index and result bytes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q      <= '0;
         b_q      <= '0;
         carry    <= 1'b0;
         idx      <= '0;
         res_sum  <= '0;
         res_cout <= 1'b0;
         res_ovf  <= 1'b0;
      end else if (accept) begin
         a_q   <= a_src;
         b_q   <= req_b ^ {W{req_sub}};
         carry <= req_sub;
         idx   <= '0;
      end else if (state == RUN) begin
         carry <= cout_byte;
         idx   <= idx + IW'(1);
         for (int i = 0; i < NBYTES; i++) begin
            if (idx == IW'(i)) res_sum[i*BYTE_W +: BYTE_W] <= sum_byte;
         end
         if (last) begin
            res_cout <= cout_byte;
            res_ovf  <= (a_q[NBYTES-1][BYTE_W-1] == b_q[NBYTES-1][BYTE_W-1])
                     && (sum_byte[BYTE_W-1] != a_q[NBYTES-1][BYTE_W-1]);
         end
      end
   end

endmodule

// File: tb/tb_multibyte_add_seq.sv
// Directed self-checking bench for multibyte_add_seq (NBYTES=4).
// Covers carry ripple, subtract, overflow, result hold, reset abort, accumulate.
module tb_multibyte_add_seq;

   localparam int NB = 4;
   localparam int W  = 8 * NB;

   logic         clk = 1'b0;
   logic         rst;
   logic         req_valid;
   logic         req_ready;
   logic         req_sub;
   logic [W-1:0] req_a;
   logic [W-1:0] req_b;
   logic         req_acc;
   logic         res_valid;
   logic         res_ready;
   logic [W-1:0] res_sum;
   logic         res_cout;
   logic         res_ovf;
   logic         busy;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   multibyte_add_seq #(.NBYTES(NB)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_sub   (req_sub),
      .req_a     (req_a),
      .req_b     (req_b),
`ifdef ACC_CHAIN_EN
      .req_acc   (req_acc),
`endif
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_sum   (res_sum),
      .res_cout  (res_cout),
      .res_ovf   (res_ovf),
      .busy      (busy)
   );

   // drive one request, wait for the result, consume it
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input logic acc,
                        output logic [W-1:0] sum, output logic cout,
                        output logic ovf, output int lat);
      int guard;
      guard = 0;
      while (!req_ready && guard < 20) begin
         @(posedge clk); #1;
         guard++;
      end
      req_valid = 1'b1;
      req_a     = a;
      req_b     = b;
      req_sub   = sub;
      req_acc   = acc;
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_a     = 32'hDEAD_BEEF;
      req_b     = 32'h5A5A_A5A5;
      req_sub   = ~sub;
      req_acc   = 1'b0;
      lat = 0;
      while (!res_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      sum  = res_sum;
      cout = res_cout;
      ovf  = res_ovf;
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      #12;
      n_checks++;
      if (req_ready !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_hs: ready=%b valid=%b busy=%b want 1 0 0",
                  req_ready, res_valid, busy);
      end
      n_checks++;
      if (res_sum !== 32'h0 || res_cout !== 1'b0 || res_ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_res: sum=%h cout=%b ovf=%b want 0 0 0",
                  res_sum, res_cout, res_ovf);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_add();
      logic [W-1:0] s; logic c, o; int lat;
      do_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, s, c, o, lat);
      n_checks++;
      if (s !== 32'h0000_0100 || c !== 1'b0 || o !== 1'b0) begin
         n_fail++;
         $display("FAIL add_ff_1: got %h c%b o%b want 00000100 c0 o0", s, c, o);
      end
      n_checks++;
      if (lat !== NB) begin
         n_fail++;
         $display("FAIL latency: got %0d want %0d", lat, NB);
      end
      do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, s, c, o, lat);
      n_checks++;
      if (s !== 32'h0 || c !== 1'b1 || o !== 1'b0) begin
         n_fail++;
         $display("FAIL add_ripple: got %h c%b o%b want 00000000 c1 o0", s, c, o);
      end
      do_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, s, c, o, lat);
      n_checks++;
      if (s !== 32'hACF1_3568 || c !== 1'b0 || o !== 1'b0) begin
         n_fail++;
         $display("FAIL add_mixed: got %h c%b o%b want acf13568 c0 o0", s, c, o);
      end
   endtask

   task automatic test_sub();
      logic [W-1:0] s; logic c, o; int lat;
      do_op(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, s, c, o, lat);
      n_checks++;
      if (s !== 32'hFFFF_FFFE || c !== 1'b0 || o !== 1'b0) begin
         n_fail++;
         $display("FAIL sub_borrow: got %h c%b o%b want fffffffe c0 o0", s, c, o);
      end
      do_op(32'h0000_1234, 32'h0000_1234, 1'b1, 1'b0, s, c, o, lat);
      n_checks++;
      if (s !== 32'h0 || c !== 1'b1 || o !== 1'b0) begin
         n_fail++;
         $display("FAIL sub_equal: got %h c%b o%b want 00000000 c1 o0", s, c, o);
      end
   endtask

   task automatic test_ovf();
      logic [W-1:0] s; logic c, o; int lat;
      do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, s, c, o, lat);
      n_checks++;
      if (s !== 32'h8000_0000 || c !== 1'b0 || o !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_add: got %h c%b o%b want 80000000 c0 o1", s, c, o);
      end
      do_op(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, s, c, o, lat);
      n_checks++;
      if (s !== 32'h7FFF_FFFF || c !== 1'b1 || o !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_sub: got %h c%b o%b want 7fffffff c1 o1", s, c, o);
      end
   endtask

   task automatic test_hold();
      int lat; int bad;
      req_valid = 1'b1;
      req_a     = 32'h0000_0010;
      req_b     = 32'h0000_0020;
      req_sub   = 1'b0;
      req_acc   = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 0;
      while (!res_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      bad = 0;
      req_valid = 1'b1;
      req_a     = 32'h1111_1111;
      req_b     = 32'h2222_2222;
      for (int k = 0; k < 3; k++) begin
         n_checks++;
         if (res_valid !== 1'b1 || req_ready !== 1'b0 || busy !== 1'b1
             || res_sum !== 32'h0000_0030) begin
            n_fail++;
            bad++;
            $display("FAIL hold_%0d: valid=%b ready=%b busy=%b sum=%h want 1 0 1 00000030",
                     k, res_valid, req_ready, busy, res_sum);
         end
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      n_checks++;
      if (req_ready !== 1'b1 || res_valid !== 1'b0 || res_sum !== 32'h0000_0030) begin
         n_fail++;
         $display("FAIL hold_release: ready=%b valid=%b sum=%h want 1 0 00000030",
                  req_ready, res_valid, res_sum);
      end
   endtask

   task automatic test_reset_mid();
      logic [W-1:0] s; logic c, o; int lat; int seen;
      req_valid = 1'b1;
      req_a     = 32'h0F0F_0F0F;
      req_b     = 32'h0101_0101;
      req_sub   = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      n_checks++;
      if (req_ready !== 1'b1 || busy !== 1'b0 || res_valid !== 1'b0
          || res_sum !== 32'h0) begin
         n_fail++;
         $display("FAIL rst_mid: ready=%b busy=%b valid=%b sum=%h want 1 0 0 0",
                  req_ready, busy, res_valid, res_sum);
      end
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         if (res_valid) seen++;
      end
      n_checks++;
      if (seen !== 0) begin
         n_fail++;
         $display("FAIL rst_no_valid: res_valid seen %0d cycles want 0", seen);
      end
      do_op(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, s, c, o, lat);
      n_checks++;
      if (s !== 32'h0000_0003 || c !== 1'b0 || o !== 1'b0) begin
         n_fail++;
         $display("FAIL after_rst: got %h c%b o%b want 00000003 c0 o0", s, c, o);
      end
   endtask

`ifdef ACC_CHAIN_EN
   task automatic test_acc();
      logic [W-1:0] s; logic c, o; int lat;
      do_op(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, s, c, o, lat);
      do_op(32'hFFFF_0000, 32'h0000_0004, 1'b0, 1'b1, s, c, o, lat);
      n_checks++;
      if (s !== 32'h0000_0007) begin
         n_fail++;
         $display("FAIL acc_chain: got %h want 00000007", s);
      end
   endtask
`endif

   initial begin
      req_valid = 1'b0;
      req_sub   = 1'b0;
      req_a     = '0;
      req_b     = '0;
      req_acc   = 1'b0;
      res_ready = 1'b0;
      test_reset();
      test_add();
      test_sub();
      test_ovf();
      test_hold();
      test_reset_mid();
`ifdef ACC_CHAIN_EN
      test_acc();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
